// File: rtl/fifo_wr_mem_if.sv
// Write-side bus of the async FIFO write half: write request/data, synchronised read
// pointer, asynchronous read lookup, and the write-domain status outputs.
interface fifo_wr_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  wfull;
    logic                  wovf;
    logic [ADDR_WIDTH:0]   wcount;
    logic                  almost_full;

    modport master (
        output winc, wdata, wq2_rptr, raddr,
        input  rdata, wptr, wfull, wovf, wcount, almost_full
    );

    modport slave (
        input  winc, wdata, wq2_rptr, raddr,
        output rdata, wptr, wfull, wovf, wcount, almost_full
    );
endinterface

// File: rtl/fifo_wr_mem.sv
// Async FIFO write half: storage array, binary/Gray write pointer, full, overflow and fill level.
// Optional almost_full threshold logic is built only when FIFO_WR_MEM_AFULL_EN is defined.
module fifo_wr_mem #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 2
) (
    input  logic          wclk,
    input  logic          wrst_n,
    fifo_wr_mem_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wbin;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_wcount;
    logic                  r_wfull;
    logic                  r_wovf;

    logic                  w_wen;
    logic [PW-1:0]         w_wbin_next;
    logic [PW-1:0]         w_wgray_next;
    logic [PW-1:0]         w_rbin;
    logic [PW-1:0]         w_full_cmp;
    logic [PW-1:0]         w_wcount_next;
    logic                  w_wfull_next;

    assign w_wen         = bus.winc & ~r_wfull;
    assign w_wbin_next   = r_wbin + PW'(w_wen);
    assign w_wgray_next  = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_rbin        = gray2bin(bus.wq2_rptr);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign w_full_cmp    = {~bus.wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], bus.wq2_rptr[ADDR_WIDTH-2:0]};
    assign w_wfull_next  = (w_wgray_next == w_full_cmp);
    assign w_wcount_next = w_wbin_next - w_rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wen) begin
            r_mem[r_wbin[ADDR_WIDTH-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wcount <= '0;
            r_wfull  <= 1'b0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wptr   <= w_wgray_next;
            r_wcount <= w_wcount_next;
            r_wfull  <= w_wfull_next;
            r_wovf   <= bus.winc & r_wfull;
        end
    end

`ifdef FIFO_WR_MEM_AFULL_EN
    logic r_afull;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (w_wcount_next >= PW'(DEPTH - AFULL_THRESH));
        end
    end

    assign bus.almost_full = r_afull;
`else
    assign bus.almost_full = 1'b0;
`endif

    assign bus.rdata  = r_mem[bus.raddr];
    assign bus.wptr   = r_wptr;
    assign bus.wcount = r_wcount;
    assign bus.wfull  = r_wfull;
    assign bus.wovf   = r_wovf;
endmodule
